featuremap_channel_accumulator: RTL and testbench
=================================================

Name: featuremap_channel_accumulator

Overview:
- Parametrised successor to the fixed 16-channel filter-output stage. Sums NUM_CH per-channel conv2D results plus the filter bias into one output-feature-map pixel.
- Uses a single shared fp32 adder, serially over channels, instead of one adder per channel.
- Sits between the per-channel conv2D line-buffer instances and the next layer's FIFO.
- Adds a runtime active-channel count, valid/ready handshakes on both sides, and end-of-frame marking.

Parameters:
- DATA_WIDTH, 32: IEEE-754 single-precision word width; only 32 is supported.
- NUM_CH, 16: maximum number of input channels; legal range 1..64.
- WIDTH, 56: output feature-map width and height; the frame is WIDTH*WIDTH pixels.
- BIAS, 32'h00000000: fp32 bias for this filter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- in_data  in  NUM_CH*DATA_WIDTH  packed conv2D outputs; channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- in_valid  in  1  all channel values present (upstream ANDs the per-channel valids)
- in_ready  out  1  block accepts in_data this cycle
- cfg_num_ch  in  $clog2(NUM_CH+1)  number of channels to sum, starting from channel 0
- out_data  out  DATA_WIDTH  fp32 pixel result
- out_valid  out  1  out_data is valid
- out_ready  in  1  downstream accepts out_data
- out_last  out  1  qualifies out_data as the last pixel of the frame

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE; out_valid=0; out_data=0; out_last=0; pixel counter=0; accumulator=0; in_ready=0 in the reset cycle, then 1 from the next cycle.
- Reset mid-operation discards any partial sum and any pending output. No output is produced for that pixel.
- State machine IDLE -> ACC -> OUT:
  - IDLE: in_ready=1.
    - On in_valid & in_ready, register in_data into a channel buffer.
    - Sample cfg_num_ch as n. Clamp n to NUM_CH if larger.
    - Set acc=BIAS and idx=0.
    - Go to ACC if n>0; if n==0, go directly to OUT with out_data=BIAS.
  - ACC: each cycle, acc <= fp32_add(acc, buf[idx]) and idx++. After idx==n-1 is added, go to OUT. ACC lasts exactly n cycles.
  - OUT: out_valid=1; out_data=acc (post-processed, see Optional Feature); out_last=(pix_cnt==WIDTH*WIDTH-1).
    - out_data and out_last are held stable while out_ready=0.
    - On out_ready: pix_cnt increments, or wraps to 0 after the last pixel.
    - in_ready=out_ready in OUT, so a new pixel may be captured in the same cycle (back-to-back). The next state is then ACC, or OUT if the new n==0; otherwise IDLE.
- Latency: a handshake at cycle t gives out_valid at t+n+1.
- Throughput: one pixel per n+1 cycles with out_ready held at 1.
- Summation order is fixed: bias first, then channel 0 to n-1. Results must be bit-exact to this order.
- cfg_num_ch is ignored except in the capture cycle.
- The channel buffer is never overwritten during ACC.
- NaN/Inf propagate as fp32_add defines; the block applies no special handling.

Optional Feature:
- Macro: FEATUREMAP_ACC_RELU_EN.
- Defined: out_data = (acc[31]==1) ? 32'h00000000 : acc. This applies ReLU and flushes -0.0 to +0.0. It is applied combinationally on the OUT register input and adds no latency.
- Undefined: out_data = acc unchanged. A separate activation block follows.

Decomposition:
- Package featuremap_pkg:
  - FP32_ZERO constant
  - fp32_t typedef (DATA_WIDTH bit vector)
  - acc_state_t enum {IDLE, ACC, OUT}
  - helper function for the pixel-counter width, $clog2(WIDTH*WIDTH)
- One sub-module, fp32_add: combinational IEEE-754 single-precision adder, round-to-nearest-even, shared with the existing bias adders.
- Channel-buffer selection is an indexed part-select inside the top; it is not a separate module.

Test Plan:
- NUM_CH=4, BIAS=0x3F800000 (1.0), all channels 0x3F800000, cfg_num_ch=4: out_data=0x40A00000 (5.0) with out_valid exactly 5 cycles after the handshake.
- Same data with cfg_num_ch=2: out_data=0x40400000 (3.0) after 3 cycles. cfg_num_ch=0: out_data=0x3F800000 after 1 cycle. cfg_num_ch=7 (>NUM_CH): clamped result 0x40A00000.
- BIAS=0xC0000000 (-2.0), channels all 0x00000000: out_data=0x00000000 with FEATUREMAP_ACC_RELU_EN defined; 0xC0000000 without it.
- Backpressure: hold out_ready=0 for 10 cycles in OUT. out_data and out_valid stay stable, and in_ready=0. Release out_ready with in_valid=1: capture occurs in the same cycle and the next result follows n+1 cycles later.
- WIDTH=2, stream 9 pixels with out_ready=1: out_last=1 on pixels 4 and 8 only, and the counter wraps.
- Assert rst during ACC at cycle 2: the next cycle has out_valid=0 and in_ready=0; one cycle later in_ready=1. The partial sum never appears, and the following pixel's result is correct from BIAS.

Source files
------------

// File: rtl/featuremap_pkg.sv
// Shared types and helpers for the feature-map channel accumulator.
package featuremap_pkg;

    localparam int DATA_W = 32;

    typedef logic [DATA_W-1:0] fp32_t;

    localparam fp32_t FP32_ZERO = '0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        OUT  = 2'd2
    } acc_state_t;

    function automatic int pix_cnt_w(input int width);
        return (width * width > 1) ? $clog2(width * width) : 1;
    endfunction

endpackage

// File: rtl/fp32_add.sv
// Combinational IEEE-754 single-precision adder, round-to-nearest-even.
module fp32_add
    import featuremap_pkg::*;
(
    input  fp32_t a_i,
    input  fp32_t b_i,
    output fp32_t sum_o
);

    logic        swap;
    fp32_t       x;
    fp32_t       y;
    logic [9:0]  ex;
    logic [9:0]  ey;
    logic [9:0]  d;
    logic [9:0]  exp_r;
    logic [9:0]  sft;
    logic [26:0] mx;
    logic [26:0] my;
    logic [26:0] my_sh;
    logic [53:0] sh_t;
    logic [27:0] s;
    logic [26:0] sn;
    logic [4:0]  lz;
    logic        found;
    logic        rnd;
    logic [24:0] mr;
    logic        a_nan;
    logic        b_nan;
    logic        a_inf;
    logic        b_inf;
    fp32_t       res;

    always_comb begin
        swap  = b_i[30:0] > a_i[30:0];
        x     = swap ? b_i : a_i;
        y     = swap ? a_i : b_i;
        ex    = (x[30:23] == 8'd0) ? 10'd1 : {2'b0, x[30:23]};
        ey    = (y[30:23] == 8'd0) ? 10'd1 : {2'b0, y[30:23]};
        mx    = {x[30:23] != 8'd0, x[22:0], 3'b000};
        my    = {y[30:23] != 8'd0, y[22:0], 3'b000};
        d     = ex - ey;
        // shifted-out bits collapse into the sticky bit
        sh_t  = {my, 27'b0} >> ((d > 10'd27) ? 10'd27 : d);
        my_sh = sh_t[53:27] | {26'b0, |sh_t[26:0]};
        if (x[31] == y[31]) s = {1'b0, mx} + {1'b0, my_sh};
        else                s = {1'b0, mx} - {1'b0, my_sh};
        lz    = 5'd0;
        found = 1'b0;
        sft   = 10'd0;
        exp_r = ex;
        if (s[27]) begin
            sn    = {s[27:2], s[1] | s[0]};
            exp_r = ex + 10'd1;
        end else begin
            sn = s[26:0];
            for (int i = 26; i >= 0; i--) begin
                if (!found) begin
                    if (sn[i]) found = 1'b1;
                    else       lz = lz + 5'd1;
                end
            end
            sft   = ({5'b0, lz} < ex - 10'd1) ? {5'b0, lz} : ex - 10'd1;
            sn    = sn << sft;
            exp_r = ex - sft;
        end
        rnd = sn[2] & (sn[1] | sn[0] | sn[3]);
        mr  = {1'b0, sn[26:3]} + {24'b0, rnd};
        if (mr[24]) begin
            mr    = mr >> 1;
            exp_r = exp_r + 10'd1;
        end
        if (exp_r >= 10'd255) res = {x[31], 8'hFF, 23'b0};
        else res = {x[31], mr[23] ? exp_r[7:0] : 8'h00, mr[22:0]};
        if (s == 28'd0) res = {x[31] & y[31], 31'b0};
        a_nan = (&a_i[30:23]) & (|a_i[22:0]);
        b_nan = (&b_i[30:23]) & (|b_i[22:0]);
        a_inf = (&a_i[30:23]) & ~(|a_i[22:0]);
        b_inf = (&b_i[30:23]) & ~(|b_i[22:0]);
        if (a_nan | b_nan | (a_inf & b_inf & (a_i[31] != b_i[31])))
            res = 32'h7FC00000;
        else if (a_inf)
            res = a_i;
        else if (b_inf)
            res = b_i;
    end

    assign sum_o = res;

endmodule

// File: rtl/featuremap_channel_accumulator.sv
// Serial bias + channel fp32 summation into one output-map pixel.
// Define FEATUREMAP_ACC_RELU_EN to apply ReLU on the output register input.
module featuremap_channel_accumulator
    import featuremap_pkg::*;
#(
    parameter int          DATA_WIDTH = 32,
    parameter int          NUM_CH     = 16,
    parameter int          WIDTH      = 56,
    parameter logic [31:0] BIAS       = 32'h00000000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_CH*DATA_WIDTH-1:0] in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [$clog2(NUM_CH+1)-1:0]  cfg_num_ch,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         out_last
);

    localparam int CW = $clog2(NUM_CH + 1);
    localparam int PW = pix_cnt_w(WIDTH);
    localparam logic [CW-1:0] NMAX = CW'(NUM_CH);
    localparam logic [PW-1:0] LAST = PW'(WIDTH * WIDTH - 1);

    acc_state_t                   state_q, state_d;
    logic [NUM_CH*DATA_WIDTH-1:0] buf_q, buf_d;
    fp32_t                        acc_q, acc_d;
    fp32_t                        out_q, out_d;
    logic [CW-1:0]                idx_q, idx_d;
    logic [CW-1:0]                n_q, n_d;
    logic [PW-1:0]                pix_q, pix_d;
    logic                         rdy_q;
    logic [CW-1:0]                n_cap;
    logic                         take;
    fp32_t                        sum;

    function automatic fp32_t post(input fp32_t v);
`ifdef FEATUREMAP_ACC_RELU_EN
        return v[31] ? FP32_ZERO : v;
`else
        return v;
`endif
    endfunction

    fp32_add u_add (
        .a_i  (acc_q),
        .b_i  (buf_q[idx_q*DATA_WIDTH +: DATA_WIDTH]),
        .sum_o(sum)
    );

    assign in_ready  = ((state_q == IDLE) & rdy_q) |
                       ((state_q == OUT) & out_ready);
    assign take      = in_valid & in_ready;
    assign n_cap     = (cfg_num_ch > NMAX) ? NMAX : cfg_num_ch;
    assign out_valid = (state_q == OUT);
    assign out_data  = out_q;
    assign out_last  = (state_q == OUT) & (pix_q == LAST);

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        acc_d   = acc_q;
        out_d   = out_q;
        idx_d   = idx_q;
        n_d     = n_q;
        pix_d   = pix_q;
        unique case (state_q)
            IDLE: ;
            ACC: begin
                acc_d = sum;
                idx_d = idx_q + CW'(1);
                if (idx_q == n_q - CW'(1)) begin
                    state_d = OUT;
                    out_d   = post(sum);
                end
            end
            OUT: begin
                if (out_ready) begin
                    pix_d   = (pix_q == LAST) ? '0 : pix_q + PW'(1);
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // capture may coincide with the OUT handshake for back-to-back pixels
        if (take) begin
            buf_d = in_data;
            n_d   = n_cap;
            acc_d = BIAS;
            idx_d = '0;
            if (n_cap == '0) begin
                state_d = OUT;
                out_d   = post(BIAS);
            end else begin
                state_d = ACC;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            buf_q   <= '0;
            acc_q   <= FP32_ZERO;
            out_q   <= FP32_ZERO;
            idx_q   <= '0;
            n_q     <= '0;
            pix_q   <= '0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            acc_q   <= acc_d;
            out_q   <= out_d;
            idx_q   <= idx_d;
            n_q     <= n_d;
            pix_q   <= pix_d;
            rdy_q   <= 1'b1;
        end
    end

endmodule

// File: tb/tb_featuremap_channel_accumulator.sv
// Directed bench for featuremap_channel_accumulator (NUM_CH=4, WIDTH=2).
module tb_featuremap_channel_accumulator;

    localparam int NCH = 4;
    localparam int DW  = 32;
    localparam int CW  = $clog2(NCH + 1);
    localparam logic [31:0] ONE = 32'h3F800000;

    logic              clk = 1'b0;
    logic              rst;
    logic [NCH*DW-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [CW-1:0]     cfg;
    logic [DW-1:0]     out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;
    logic              in_valid2;
    logic              in_ready2;
    logic [DW-1:0]     out_data2;
    logic              out_valid2;
    logic              out_ready2;
    logic              out_last2;

    int n_chk = 0;
    int n_err = 0;
    int exp_pix = 0;

    always #5 clk = ~clk;

    featuremap_channel_accumulator #(
        .DATA_WIDTH(DW), .NUM_CH(NCH), .WIDTH(2), .BIAS(32'h3F800000)
    ) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .cfg_num_ch(cfg), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last)
    );

    featuremap_channel_accumulator #(
        .DATA_WIDTH(DW), .NUM_CH(NCH), .WIDTH(2), .BIAS(32'hC0000000)
    ) dut2 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid2),
        .in_ready(in_ready2), .cfg_num_ch(cfg), .out_data(out_data2),
        .out_valid(out_valid2), .out_ready(out_ready2), .out_last(out_last2)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [NCH*DW-1:0] pk(input logic [31:0] c0, c1, c2, c3);
        return {c3, c2, c1, c0};
    endfunction

    task automatic send(input string tag, input logic [NCH*DW-1:0] d,
                        input logic [CW-1:0] c, input int n,
                        input logic [31:0] exp);
        int t;
        int lat;
        in_data  = d;
        cfg      = c;
        in_valid = 1'b1;
        t = 0;
        while (!in_ready && t < 20) begin
            step();
            t++;
        end
        chk({tag, "_rdy"}, 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        cfg      = 3'd1;
        in_data  = {NCH{32'h7F800000}};
        lat = 1;
        while (!out_valid && lat < 100) begin
            step();
            lat++;
        end
        chk({tag, "_lat"}, 32'(lat), 32'(n + 1));
        chk({tag, "_dat"}, out_data, exp);
        chk({tag, "_last"}, 32'(out_last), 32'(exp_pix == 3));
        exp_pix = (exp_pix + 1) % 4;
        step();
    endtask

    initial begin
        int lat;
        logic [NCH*DW-1:0] all1;
        all1       = pk(ONE, ONE, ONE, ONE);
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_valid2  = 1'b0;
        out_ready  = 1'b1;
        out_ready2 = 1'b1;
        in_data    = '0;
        cfg        = '0;
        step();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", out_data, 32'd0);
        chk("rst_last", 32'(out_last), 32'd0);
        chk("rst_rdy", 32'(in_ready), 32'd0);
        rst = 1'b0;
        step();
        chk("post_rst_rdy", 32'(in_ready), 32'd1);

        send("n4", all1, 3'd4, 4, 32'h40A00000);
        send("n2", all1, 3'd2, 2, 32'h40400000);
        send("n0", all1, 3'd0, 0, 32'h3F800000);
        send("n7", all1, 3'd7, 4, 32'h40A00000);
        send("mix", pk(32'h3F800000, 32'h40000000, 32'h3F000000, 32'hC0400000),
             3'd4, 4, 32'h3FC00000);
        send("tie", pk(32'h33800000, 32'h33800001, 0, 0), 3'd1, 1, 32'h3F800000);
        send("rnd", pk(32'h33800001, 32'h33800000, 0, 0), 3'd1, 1, 32'h3F800001);
        send("ord", pk(32'h33800000, 32'h33800000, 0, 0), 3'd2, 2, 32'h3F800000);

        // backpressure, then back-to-back capture on release
        out_ready = 1'b0;
        in_data   = all1;
        cfg       = 3'd4;
        in_valid  = 1'b1;
        #1;
        chk("bp_cap_rdy", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            step();
            lat++;
        end
        chk("bp_lat", 32'(lat), 32'd5);
        for (int i = 0; i < 10; i++) begin
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_data", out_data, 32'h40A00000);
            chk("bp_rdy", 32'(in_ready), 32'd0);
            step();
        end
        chk("bp_last", 32'(out_last), 32'(exp_pix == 3));
        in_data   = pk(32'h40000000, 32'h40000000, 0, 0);
        cfg       = 3'd1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("b2b_rdy", 32'(in_ready), 32'd1);
        step();
        exp_pix  = (exp_pix + 1) % 4;
        in_valid = 1'b0;
        chk("b2b_acc", 32'(out_valid), 32'd0);
        lat = 1;
        while (!out_valid && lat < 100) begin
            step();
            lat++;
        end
        chk("b2b_lat", 32'(lat), 32'd2);
        chk("b2b_dat", out_data, 32'h40400000);
        chk("b2b_last", 32'(out_last), 32'(exp_pix == 3));
        exp_pix = (exp_pix + 1) % 4;
        step();

        // reset in the second ACC cycle
        in_data  = all1;
        cfg      = 3'd4;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_pix = 0;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_rdy", 32'(in_ready), 32'd0);
        step();
        chk("mid_rst_rdy1", 32'(in_ready), 32'd1);
        chk("mid_rst_valid1", 32'(out_valid), 32'd0);
        send("after_rst", all1, 3'd2, 2, 32'h40400000);

        // frame of 2x2: last on every 4th pixel, counter wraps
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        exp_pix = 0;
        for (int k = 0; k < 9; k++)
            send("frame", all1, 3'd1, 1, 32'h40000000);

        // negative bias through the second instance
        in_data   = '0;
        cfg       = 3'd4;
        in_valid2 = 1'b1;
        #1;
        chk("neg_rdy", 32'(in_ready2), 32'd1);
        step();
        in_valid2 = 1'b0;
        lat = 1;
        while (!out_valid2 && lat < 100) begin
            step();
            lat++;
        end
        chk("neg_lat", 32'(lat), 32'd5);
`ifdef FEATUREMAP_ACC_RELU_EN
        chk("neg_dat", out_data2, 32'h00000000);
`else
        chk("neg_dat", out_data2, 32'hC0000000);
`endif
        chk("neg_last", 32'(out_last2), 32'd0);
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
